// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the display VRAM fill master.
// Every burst is sixteen 8-byte beats (128 bytes) into the 0x2000_0000 VRAM window.
package disp_pkg;

    localparam logic [2:0] SIZE_8B      = 3'b011;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [3:0] CACHE_DEF    = 4'b0011;
    localparam int         BURST_BEATS  = 16;
    localparam int         BURST_BYTES  = 128;
    localparam logic [2:0] VRAM_BASE_HI = 3'b001;
    localparam logic [7:0] AWLEN_FIXED  = 8'(BURST_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } state_t;

endpackage

// File: rtl/disp_vram_filler.sv
// AXI4 write master that fills a contiguous VRAM region with one solid colour,
// one burst at a time (AW, then 16 W beats, then B).
module disp_vram_filler
    import disp_pkg::*;
#(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 64
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETN,

    input  logic                                 START,
    input  logic [28:0]                          BASEADDR,
    input  logic [15:0]                          NBURST,
    input  logic [23:0]                          COLOR,
    output logic                                 BUSY,
    output logic                                 DONE,
    output logic                                 ERR,
    output logic [1:0]                           DBG_STATE,

    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_AWADDR,
    output logic [7:0]                           M_AXI_AWLEN,
    output logic [2:0]                           M_AXI_AWSIZE,
    output logic [1:0]                           M_AXI_AWBURST,
    output logic                                 M_AXI_AWLOCK,
    output logic [3:0]                           M_AXI_AWCACHE,
    output logic [2:0]                           M_AXI_AWPROT,
    output logic [3:0]                           M_AXI_AWQOS,
    output logic                                 M_AXI_AWUSER,
    output logic                                 M_AXI_AWVALID,
    input  logic                                 M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
    output logic                                 M_AXI_WLAST,
    output logic                                 M_AXI_WUSER,
    output logic                                 M_AXI_WVALID,
    input  logic                                 M_AXI_WREADY,

    input  logic [1:0]                           M_AXI_BRESP,
    input  logic                                 M_AXI_BVALID,
    output logic                                 M_AXI_BREADY
);

    state_t      state_q, state_d;
    logic [28:0] addr_q;
    logic [15:0] rem_q;
    logic [23:0] color_q;
    logic [3:0]  beat_q;
    logic        done_q;
    logic        err_q;
    logic        accept;
    logic        last_beat;
    logic        unused_baseaddr;

    // Low address bits are discarded by the 128-byte alignment.
    assign unused_baseaddr = ^BASEADDR[6:0];

    assign accept    = (state_q == IDLE) && START && (NBURST != 16'd0);
    assign last_beat = (beat_q == 4'(BURST_BEATS - 1));

    // Handshakes: a transfer happens on a rising ACLK edge where VALID and
    // READY are both high; VALID is raised purely from state, never waits on
    // READY, and VALID plus its payload stay frozen until that edge.
    always_comb begin
        state_d       = state_q;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        BUSY          = (state_q != IDLE);
        DONE          = done_q;
        ERR           = err_q;
        DBG_STATE     = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = AW;
            end
            AW: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) state_d = W;
            end
            W: begin
                M_AXI_WVALID = 1'b1;
                M_AXI_WLAST  = last_beat;
                if (M_AXI_WREADY && last_beat) state_d = B;
            end
            B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_d = (rem_q == 16'd1) ? IDLE : AW;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            color_q <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A zero-length request completes immediately without traffic.
                    if (START && (NBURST == 16'd0)) done_q <= 1'b1;
                    if (accept) begin
                        addr_q  <= {BASEADDR[28:7], 7'b0};
                        rem_q   <= NBURST;
                        color_q <= COLOR;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                W: begin
                    if (M_AXI_WREADY) beat_q <= beat_q + 4'd1;
                end
                B: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) err_q <= 1'b1;
                        rem_q  <= rem_q - 16'd1;
                        // 29-bit wrap keeps the region inside the VRAM window.
                        addr_q <= addr_q + 29'(BURST_BYTES);
                        if (rem_q == 16'd1) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({VRAM_BASE_HI, addr_q});
    assign M_AXI_AWLEN   = AWLEN_FIXED;
    assign M_AXI_AWSIZE  = SIZE_8B;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = CACHE_DEF;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWUSER  = 1'b0;
    // Two 24-bit pixels per 64-bit beat, each padded to 32 bits.
    assign M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'({8'h00, color_q, 8'h00, color_q});
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WUSER   = 1'b0;

endmodule

// File: tb/tb_disp_vram_filler.sv
// Self-checking bench for disp_vram_filler: table of fills plus random fills
// scored by an AXI slave model, and hand-written reset / zero-length sequences.
module tb_disp_vram_filler;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        START;
    logic [28:0] BASEADDR;
    logic [15:0] NBURST;
    logic [23:0] COLOR;
    logic        BUSY, DONE, ERR;
    logic [1:0]  DBG_STATE;
    logic [0:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic [3:0]  AWQOS;
    logic        AWUSER, AWVALID, AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WUSER, WVALID, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;

    always #5 ACLK = ~ACLK;

    disp_vram_filler dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .START(START), .BASEADDR(BASEADDR), .NBURST(NBURST), .COLOR(COLOR),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE),
        .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN),
        .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK),
        .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS),
        .M_AXI_AWUSER(AWUSER), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
        .M_AXI_WUSER(WUSER), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
    );

    typedef struct {
        logic [28:0] base;
        logic [15:0] nburst;
        logic [23:0] color;
        int          err_burst;
        bit          stall;
        bit          extra_start;
        bit          exp_err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard / slave model state
    logic [31:0] exp_q[$];
    logic [23:0] exp_color = '0;
    int  err_burst = -1;
    bit  stall = 0;
    int  w_beat = 0, w_total = 0, aw_total = 0, done_total = 0;
    int  b_pending = 0, b_idx = 0;
    bit  b_hs_s = 0;
    bit  prev_rst_n = 0, prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0;
    logic [31:0] prev_awaddr = '0;
    logic [64:0] prev_w = '0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] aw_model(input logic [28:0] base, input int i);
        logic [28:0] a;
        a = (base & 29'h1FFFFF80) + 29'(i * 128);
        return {3'b001, a};
    endfunction

    // Monitor: observes the values that will be sampled at the next rising edge.
    always @(negedge ACLK) begin
        b_hs_s = 0;
        if (ARESETN) begin
            if (prev_rst_n && prev_awv && !prev_awr)
                chk("aw_hold", {AWVALID, AWADDR}, {1'b1, prev_awaddr});
            if (prev_rst_n && prev_wv && !prev_wr)
                chk("w_hold", {WVALID, WLAST, WDATA}, {1'b1, prev_w});
            if (AWVALID && AWREADY) begin
                aw_total++;
                chk("aw_attr", {AWLEN, AWSIZE, AWBURST}, {8'd15, 3'b011, 2'b01});
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL aw_unexpected: got 0x%0h expected no address", AWADDR);
                end else begin
                    chk("aw_addr", 72'(AWADDR), 72'(exp_q.pop_front()));
                end
            end
            if (WVALID && WREADY) begin
                chk("w_data", {WLAST, WDATA},
                    {(w_beat == 15), 8'h00, exp_color, 8'h00, exp_color});
                if (w_beat == 15) b_pending++;
                w_beat = (w_beat + 1) % 16;
                w_total++;
            end
            if (BVALID && BREADY) begin
                b_hs_s = 1;
                b_pending--;
                b_idx++;
            end
            if (DONE) done_total++;
        end
        prev_rst_n  = ARESETN;
        prev_awv    = AWVALID;
        prev_awr    = AWREADY;
        prev_awaddr = AWADDR;
        prev_wv     = WVALID;
        prev_wr     = WREADY;
        prev_w      = {WLAST, WDATA};
    end

    // AXI slave model: random ready stalls, one response per completed burst.
    always begin
        @(posedge ACLK);
        #1;
        AWREADY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        WREADY  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (BVALID && !b_hs_s) begin
            BVALID = 1'b1;
        end else if (b_pending > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
            BVALID = 1'b1;
            BRESP  = (b_idx == err_burst) ? 2'b10 : 2'b00;
        end else begin
            BVALID = 1'b0;
            BRESP  = 2'b00;
        end
    end

    // Called at posedge+1; returns at the negedge right after START was sampled.
    task automatic start_fill(input vec_t v);
        exp_q.delete();
        for (int i = 0; i < int'(v.nburst); i++) exp_q.push_back(aw_model(v.base, i));
        exp_color = v.color;
        err_burst = v.err_burst;
        stall     = v.stall;
        w_total   = 0;
        aw_total  = 0;
        b_idx     = 0;
        w_beat    = 0;
        BASEADDR  = v.base;
        NBURST    = v.nburst;
        COLOR     = v.color;
        START     = 1'b1;
        @(posedge ACLK);
        #1;
        START    = 1'b0;
        BASEADDR = 29'($urandom);
        COLOR    = 24'($urandom);
        NBURST   = 16'($urandom);
        @(negedge ACLK);
        chk("start_state", {AWVALID, BUSY, ERR}, 3'b110);
    endtask

    task automatic finish_fill(input vec_t v);
        int  done0;
        int  budget;
        bit  got;
        done0  = done_total;
        budget = 120 * int'(v.nburst) + 40;
        got    = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge ACLK);
            #1;
            START = (v.extra_start && c == 3);
            if (START) NBURST = 16'd1;
            @(negedge ACLK);
            if (DONE) begin
                got = 1;
                break;
            end
        end
        START = 1'b0;
        chk("done_seen", 72'(got), 72'(1));
        chk("done_state", {BUSY, ERR}, {1'b0, v.exp_err});
        chk("aw_count", 72'(aw_total), 72'(v.nburst));
        chk("w_count", 72'(w_total), 72'(16 * int'(v.nburst)));
        chk("aw_left", 72'(exp_q.size()), 72'(0));
        @(negedge ACLK);
        chk("done_pulse", 72'(DONE), 72'(0));
        repeat (4) @(negedge ACLK);
        chk("done_once", 72'(done_total - done0), 72'(1));
        @(posedge ACLK);
        #1;
    endtask

    vec_t vecs[12];
    vec_t v;
    int   z_aw0;
    bit   hit7;

    initial begin
        // Fixed scenarios
        vecs[0] = '{29'h0100000, 16'd1, 24'h123456, -1, 0, 0, 0};
        vecs[1] = '{29'h0100000, 16'd3, 24'hA5C3E1, -1, 1, 0, 0};
        vecs[2] = '{29'h0200040, 16'd2, 24'h00FF00,  1, 0, 0, 1};
        vecs[3] = '{29'h0300000, 16'd1, 24'hFF0000, -1, 1, 0, 0};
        vecs[4] = '{29'h1FFFFFC5, 16'd2, 24'h0000FF, -1, 0, 0, 0};
        vecs[5] = '{29'h1FFFFF00, 16'd3, 24'h7E7E7E,  0, 1, 0, 1};
        for (int i = 6; i < 12; i++) begin
            vecs[i].base        = 29'($urandom);
            vecs[i].nburst      = 16'($urandom_range(1, 4));
            vecs[i].color       = 24'($urandom);
            vecs[i].err_burst   = $urandom_range(0, 5) - 1;
            vecs[i].stall       = 1'($urandom_range(0, 1));
            vecs[i].extra_start = 0;
            vecs[i].exp_err     = (vecs[i].err_burst >= 0) &&
                                  (vecs[i].err_burst < int'(vecs[i].nburst));
        end

        ARESETN = 1'b0;
        START = 1'b0; BASEADDR = '0; NBURST = '0; COLOR = '0;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b00;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("reset_ctrl", {AWVALID, WVALID, BREADY, BUSY, DONE, ERR, DBG_STATE}, 8'h00);
        chk("const_aw", {AWID, AWLOCK, AWCACHE, AWPROT, AWQOS, AWUSER, WUSER, WSTRB},
            {1'b0, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0, 1'b0, 8'hFF});
        chk("reset_addr", 72'(AWADDR), 72'(32'h2000_0000));
        @(posedge ACLK);
        #1;

        for (int i = 0; i < 12; i++) begin
            start_fill(vecs[i]);
            finish_fill(vecs[i]);
        end

        // Zero-length request: DONE one cycle later, no traffic, never busy.
        stall = 0;
        z_aw0 = aw_total;
        NBURST = 16'd0;
        START  = 1'b1;
        @(negedge ACLK);
        chk("zero_pre", {DONE, BUSY, AWVALID}, 3'b000);
        @(posedge ACLK);
        #1;
        START = 1'b0;
        @(negedge ACLK);
        chk("zero_done", {DONE, BUSY, AWVALID}, 3'b100);
        @(negedge ACLK);
        chk("zero_after", {DONE, BUSY, AWVALID}, 3'b000);
        repeat (3) @(negedge ACLK);
        chk("zero_no_aw", 72'(aw_total - z_aw0), 72'(0));
        @(posedge ACLK);
        #1;

        // Reset while beat 7 of the first burst is on the bus.
        v = '{29'h0400000, 16'd2, 24'h112233, -1, 0, 0, 0};
        start_fill(v);
        hit7 = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge ACLK);
            #1;
            if (w_beat == 7 && WVALID) begin
                hit7 = 1;
                break;
            end
        end
        chk("rst_reach_beat7", 72'(hit7), 72'(1));
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        exp_q.delete();
        w_beat = 0;
        b_idx  = 0;
        @(negedge ACLK);
        chk("rst_mid", {WVALID, AWVALID, BUSY, DONE, ERR}, 5'b00000);
        @(posedge ACLK);
        #1;

        // Normal fill after reset, with a second START ignored while busy.
        v = '{29'h0500080, 16'd1, 24'hCAFE42, -1, 0, 1, 0};
        start_fill(v);
        finish_fill(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

endmodule
